// File: rtl/riscv_dram_miss_ctrl.sv
// Cache-miss sequencer: optional dirty-victim write-back, then line refill from the DRAM model.
// Define DRAM_TIMEOUT_EN to add a per-state watchdog that aborts with a bus_err pulse.
module riscv_dram_miss_ctrl #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic              miss_dirty,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              stall,
    output logic              fill_valid,
    output logic [LINE_W-1:0] fill_data,
    output logic              bus_err,
    output logic              wren,
    output logic              rden,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [LINE_W-1:0] dram_wdata,
    input  logic [LINE_W-1:0] dram_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StRefill    = 2'd2,
        StDone      = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
    logic [LINE_W-1:0] dram_wdata_q, dram_wdata_d;
    logic [LINE_W-1:0] fill_data_q, fill_data_d;
    logic              busy;
    logic              expire;

    assign busy = (state_q == StWriteback) || (state_q == StRefill);

`ifdef DRAM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q;

    // Fires in the TIMEOUT_CYC-th cycle of a state; a same-cycle mem_ready takes priority.
    assign expire = busy && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= expire && !mem_ready;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYC;
    assign expire     = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
        fill_data_d  = fill_data_q;

        unique case (state_q)
            StIdle: begin
                if (miss_valid) begin
                    fill_addr_d = fill_addr;
                    if (miss_dirty) begin
                        state_d      = StWriteback;
                        dram_addr_d  = wb_addr;
                        dram_wdata_d = wb_data;
                    end else begin
                        state_d     = StRefill;
                        dram_addr_d = fill_addr;
                    end
                end
            end
            StWriteback: begin
                if (mem_ready) begin
                    state_d     = StRefill;
                    dram_addr_d = fill_addr_q;
                end else if (expire) begin
                    state_d = StIdle;
                end
            end
            StRefill: begin
                if (mem_ready) begin
                    state_d     = StDone;
                    fill_data_d = dram_rdata;
                end else if (expire) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fill_addr_q  <= '0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            fill_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            fill_data_q  <= fill_data_d;
        end
    end

    // Strobes come straight from the state register so they cannot glitch.
    assign wren       = (state_q == StWriteback);
    assign rden       = (state_q == StRefill);
    assign fill_valid = (state_q == StDone);
    assign stall      = busy || ((state_q == StIdle) && miss_valid);
    assign fill_data  = fill_data_q;
    assign dram_addr  = dram_addr_q;
    assign dram_wdata = dram_wdata_q;

endmodule

// File: tb/tb_riscv_dram_miss_ctrl.sv
// Self-checking bench for riscv_dram_miss_ctrl: transaction-level timeline model plus directed misses.
// Watchdog scenarios are exercised only when DRAM_TIMEOUT_EN is defined.
module tb_riscv_dram_miss_ctrl;

    localparam int unsigned AW = 64;
    localparam int unsigned LW = 128;
    localparam int unsigned TO = 8;

    localparam logic [LW-1:0] LINE_A = {32{4'hA}};
    localparam logic [LW-1:0] LINE_5 = {32{4'h5}};

    logic          clk;
    logic          rst_n;
    logic          miss_valid;
    logic          miss_dirty;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] wb_data;
    logic [AW-1:0] fill_addr;
    logic          stall;
    logic          fill_valid;
    logic [LW-1:0] fill_data;
    logic          bus_err;
    logic          wren;
    logic          rden;
    logic [AW-1:0] dram_addr;
    logic [LW-1:0] dram_wdata;
    logic [LW-1:0] dram_rdata;
    logic          mem_ready;

    riscv_dram_miss_ctrl #(
        .ADDR_W     (AW),
        .LINE_W     (LW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .miss_valid(miss_valid),
        .miss_dirty(miss_dirty),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .fill_addr (fill_addr),
        .stall     (stall),
        .fill_valid(fill_valid),
        .fill_data (fill_data),
        .bus_err   (bus_err),
        .wren      (wren),
        .rden      (rden),
        .dram_addr (dram_addr),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .mem_ready (mem_ready)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // Transaction model: the outputs follow from the offset t into the current miss.
    bit            act = 1'b0;
    int            t0;
    bit            m_dirty;
    bit            m_to;
    int            m_lw;
    int            m_lr;
    logic [AW-1:0] m_wa;
    logic [AW-1:0] m_fa;
    logic [LW-1:0] m_wd;
    logic [LW-1:0] m_rd;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;
    logic [LW-1:0] m_fill  = '0;

    int n_wren = 0;
    int n_rden = 0;
    int n_fv   = 0;
    int n_be   = 0;

    typedef struct {
        logic          w;
        logic          r;
        logic          fv;
        logic          be;
        logic          st;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        logic [LW-1:0] fd;
    } exp_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LW-1:0] a, input logic [LW-1:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return {$urandom(), $urandom()};
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   t;
        int   lwe;
        int   rlen;
        int   endt;
        e.w  = 1'b0;
        e.r  = 1'b0;
        e.fv = 1'b0;
        e.be = 1'b0;
        e.st = miss_valid;
        e.a  = m_addr;
        e.wd = m_wdata;
        e.fd = m_fill;
        if (!rst_n) begin
            e.a  = '0;
            e.wd = '0;
            e.fd = '0;
        end else if (act) begin
            t    = cyc - t0;
            lwe  = m_dirty ? m_lw : 0;
            rlen = m_to ? TO : m_lr;
            endt = lwe + rlen + 1;
            e.w  = m_dirty && (t >= 1) && (t <= lwe);
            e.r  = (t > lwe) && (t <= lwe + rlen);
            e.fv = !m_to && (t == endt);
            e.be = m_to && (t == endt);
            if (t < endt) e.st = 1'b1;
            else if (!m_to) e.st = 1'b0;
            if (t >= 1) begin
                e.a = e.w ? m_wa : m_fa;
                if (m_dirty) e.wd = m_wd;
            end
            if (e.fv) e.fd = m_rd;
        end
        return e;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        e = model_out();
        chk("wren", LW'(wren), LW'(e.w));
        chk("rden", LW'(rden), LW'(e.r));
        chk("fill_valid", LW'(fill_valid), LW'(e.fv));
        chk("bus_err", LW'(bus_err), LW'(e.be));
        chk("stall", LW'(stall), LW'(e.st));
        chk("dram_addr", LW'(dram_addr), LW'(e.a));
        chk("dram_wdata", dram_wdata, e.wd);
        chk("fill_data", fill_data, e.fd);
        if (rst_n) begin
            n_wren <= n_wren + int'(wren);
            n_rden <= n_rden + int'(rden);
            n_fv   <= n_fv + int'(fill_valid);
            n_be   <= n_be + int'(bus_err);
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) begin
            miss_valid = 1'b0;
            mem_ready  = mr;
            dram_rdata = rnd_line();
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic do_miss(input bit dirty, input logic [AW-1:0] wa, input logic [LW-1:0] wd,
                           input logic [AW-1:0] fa, input int lw, input int lr,
                           input logic [LW-1:0] rd, input bit to, input bit toggle,
                           input bit hold_next, input int abort_t);
        int lwe;
        int rlen;
        int endt;
        lwe  = dirty ? lw : 0;
        rlen = to ? int'(TO) : lr;
        endt = lwe + rlen + 1;
        m_dirty = dirty;
        m_to    = to;
        m_lw    = lw;
        m_lr    = lr;
        m_wa    = wa;
        m_fa    = fa;
        m_wd    = wd;
        m_rd    = rd;
        t0      = cyc;
        act     = 1'b1;
        miss_valid = 1'b1;
        miss_dirty = dirty;
        wb_addr    = wa;
        wb_data    = wd;
        fill_addr  = fa;
        mem_ready  = 1'b0;
        dram_rdata = rnd_line();
        for (int t = 1; t <= endt; t++) begin
            @(posedge clk);
            #1;
            miss_dirty = $urandom_range(0, 1) == 1;
            wb_addr    = rnd_addr();
            wb_data    = rnd_line();
            fill_addr  = toggle ? AW'(64'hDEAD) : rnd_addr();
            miss_valid = (t == endt) ? hold_next : (toggle && (t % 2 == 1));
            mem_ready  = (dirty && t == lwe) || (!to && t == lwe + rlen);
            dram_rdata = (!to && t == lwe + rlen) ? rd : rnd_line();
            if (t == abort_t) begin
                miss_valid = 1'b0;
                mem_ready  = 1'b0;
                #1;
                rst_n   = 1'b0;
                act     = 1'b0;
                m_addr  = '0;
                m_wdata = '0;
                m_fill  = '0;
                #1;
                chk("abort_rden_async", LW'(rden), LW'(0));
                chk("abort_stall_async", LW'(stall), LW'(0));
                chk("abort_fill_valid", LW'(fill_valid), LW'(0));
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        @(posedge clk);
        #1;
        m_addr = fa;
        if (dirty) m_wdata = wd;
        if (!to) m_fill = rd;
        act        = 1'b0;
        miss_valid = hold_next;
        mem_ready  = 1'b0;
    endtask

    initial begin
        int s_w;
        int s_r;
        int s_f;
        int s_b;
        logic [LW-1:0] rd1;
        rst_n      = 1'b0;
        miss_valid = 1'b0;
        miss_dirty = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        fill_addr  = '0;
        dram_rdata = '0;
        mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        miss_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_stall_follows_miss_valid", LW'(stall), LW'(1));
        miss_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 1'b1);

        // Clean miss, 4-cycle DRAM latency.
        s_w = n_wren; s_r = n_rden; s_f = n_fv;
        do_miss(1'b0, '0, '0, 64'h1000, 0, 4, LINE_A, 1'b0, 1'b0, 1'b0, 0);
        chk("clean_wren_cycles", LW'(n_wren - s_w), LW'(0));
        chk("clean_rden_cycles", LW'(n_rden - s_r), LW'(4));
        chk("clean_fill_pulses", LW'(n_fv - s_f), LW'(1));
        chk("clean_fill_data", fill_data, LINE_A);
        chk("clean_addr_held", LW'(dram_addr), LW'(64'h1000));
        idle(2, 1'b0);

        // Dirty miss: write-back then refill.
        s_w = n_wren; s_r = n_rden; s_f = n_fv;
        do_miss(1'b1, 64'h2000, LINE_5, 64'h3000, 3, 2, LW'(128'h1234), 1'b0, 1'b0, 1'b0, 0);
        chk("dirty_wren_cycles", LW'(n_wren - s_w), LW'(3));
        chk("dirty_rden_cycles", LW'(n_rden - s_r), LW'(2));
        chk("dirty_fill_pulses", LW'(n_fv - s_f), LW'(1));
        chk("dirty_wdata_held", dram_wdata, LINE_5);
        chk("dirty_fill_data", fill_data, LW'(128'h1234));
        idle(1, 1'b1);

        // Inputs change and miss_valid toggles after acceptance.
        s_f = n_fv; s_r = n_rden;
        do_miss(1'b0, '0, '0, 64'h1000, 0, 5, rnd_line(), 1'b0, 1'b1, 1'b0, 0);
        idle(3, 1'b0);
        chk("chg_single_fill", LW'(n_fv - s_f), LW'(1));
        chk("chg_rden_cycles", LW'(n_rden - s_r), LW'(5));
        chk("chg_addr_held", LW'(dram_addr), LW'(64'h1000));

        // Reset in the middle of a refill, then a normal miss.
        s_f = n_fv;
        do_miss(1'b0, '0, '0, 64'h4000, 0, 6, rnd_line(), 1'b0, 1'b0, 1'b0, 3);
        idle(2, 1'b1);
        chk("abort_no_fill", LW'(n_fv - s_f), LW'(0));
        chk("abort_fill_data_cleared", fill_data, LW'(0));
        rd1 = rnd_line();
        do_miss(1'b0, '0, '0, 64'h5000, 0, 1, rd1, 1'b0, 1'b0, 1'b0, 0);
        chk("post_abort_fill", fill_data, rd1);

        // Back-to-back misses with miss_valid held through DONE.
        s_f = n_fv;
        do_miss(1'b1, rnd_addr(), rnd_line(), rnd_addr(), 1, 1, rnd_line(), 1'b0, 1'b0, 1'b1, 0);
        do_miss(1'b0, '0, '0, rnd_addr(), 0, 3, rnd_line(), 1'b0, 1'b0, 1'b1, 0);
        do_miss(1'b1, rnd_addr(), rnd_line(), rnd_addr(), TO, TO, rnd_line(), 1'b0, 1'b0, 1'b0,
                0);
        chk("b2b_fill_pulses", LW'(n_fv - s_f), LW'(3));
        idle(2, 1'b0);

`ifdef DRAM_TIMEOUT_EN
        // Watchdog: DRAM never answers the refill.
        s_f = n_fv; s_b = n_be; s_r = n_rden;
        do_miss(1'b0, '0, '0, 64'h6000, 0, 0, '0, 1'b1, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        chk("to_bus_err_pulses", LW'(n_be - s_b), LW'(1));
        chk("to_no_fill", LW'(n_fv - s_f), LW'(0));
        chk("to_rden_cycles", LW'(n_rden - s_r), LW'(TO));
        // Ready on exactly the last allowed cycle wins over expiry.
        s_f = n_fv; s_b = n_be;
        do_miss(1'b0, '0, '0, 64'h7000, 0, TO, LINE_A, 1'b0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        chk("edge_fill", LW'(n_fv - s_f), LW'(1));
        chk("edge_no_bus_err", LW'(n_be - s_b), LW'(0));
`else
        s_b = n_be;
        chk("no_watchdog_bus_err", LW'(n_be - s_b), LW'(0));
`endif

        idle(2, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/riscv_dram_miss_ctrl.md
# riscv_dram_miss_ctrl

Cache-miss sequencer between the data cache and the DRAM model. It accepts one miss request per transaction. A dirty victim line is written back first, then the missing line is refilled. The block drives the DRAM `wren`/`rden` strobes, waits for the DRAM `mem_ready` pulse, and returns the fill line to the cache. It stalls the pipeline for the whole transaction.

## Interface
- `ADDR_W`, 64: byte-address width.
- `LINE_W`, 128: cache-line / DRAM data width.
- `TIMEOUT_CYC`, 32: watchdog limit in cycles; used only with `DRAM_TIMEOUT_EN`.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `miss_valid` input 1: cache miss request. Sampled only in IDLE.
- `miss_dirty` input 1: victim line is dirty and needs a write-back.
- `wb_addr` input ADDR_W: victim line address.
- `wb_data` input LINE_W: victim line data.
- `fill_addr` input ADDR_W: missing line address.
- `stall` output 1: pipeline stall.
- `fill_valid` output 1: one-cycle pulse; `fill_data` is valid.
- `fill_data` output LINE_W: refilled line.
- `bus_err` output 1: one-cycle pulse on watchdog expiry.
- `wren` output 1: DRAM write strobe.
- `rden` output 1: DRAM read strobe.
- `dram_addr` output ADDR_W: DRAM address.
- `dram_wdata` output LINE_W: DRAM write data.
- `dram_rdata` input LINE_W: DRAM read data. Valid in the cycle `mem_ready`=1.
- `mem_ready` input 1: DRAM completion pulse, one cycle.

## Operation
- FSM states: IDLE, WRITEBACK, REFILL, DONE. Encoding is free.
- IDLE:
  - `miss_valid`=1 and `miss_dirty`=1 → WRITEBACK.
  - `miss_valid`=1 and `miss_dirty`=0 → REFILL.
  - On acceptance, register `wb_addr`, `wb_data` and `fill_addr`. Inputs may change afterwards.
- WRITEBACK:
  - `wren`=1, `dram_addr`=registered `wb_addr`, `dram_wdata`=registered `wb_data`.
  - On `mem_ready`=1 → REFILL.
- REFILL:
  - `rden`=1, `dram_addr`=registered `fill_addr`.
  - On `mem_ready`=1, capture `dram_rdata` into `fill_data` → DONE.
- DONE: `fill_valid`=1 for exactly one cycle → IDLE.
- Strobes are decoded from state only, so they are glitch-free.
  - `wren` and `rden` are never both 1.
  - Both strobes are 0 in IDLE and DONE.
- `stall` = (state≠IDLE and state≠DONE), or (state==IDLE and `miss_valid`). The core resumes in the DONE cycle, concurrent with `fill_valid`.
- `mem_ready` is ignored in IDLE and DONE.
- DRAM latency is not fixed. The block waits for `mem_ready` indefinitely, unless the watchdog is enabled.
- `miss_valid` in WRITEBACK, REFILL or DONE is ignored. No request queueing.
- `fill_data` holds its value until the next refill capture.
- `dram_addr`/`dram_wdata` in IDLE/DONE: hold the last value. They are don't-care to the DRAM.

## Timing
- Reset values (async assert, sync deassert by the system):
  - state=IDLE.
  - `wren`, `rden`, `fill_valid`, `bus_err` = 0.
  - `fill_data`, `dram_addr`, `dram_wdata` = 0.
  - `stall` = `miss_valid` (combinational).
- Reset mid-transaction: strobes drop immediately, no `fill_valid`, and the FSM restarts in IDLE.
- Acceptance edge → strobe high the next cycle.
- `mem_ready` cycle → the next cycle is:
  - the REFILL strobe (coming from WRITEBACK), or
  - `fill_valid` (coming from REFILL).
- The strobe is low in the cycle after `mem_ready`.
  - Exception: WRITEBACK → REFILL, where `rden` rises immediately. The DRAM counter sees a new request.
- Clean-miss latency = 1 + DRAM latency + 1 cycles. Dirty-miss latency = 1 + 2×DRAM latency + 1 cycles.

## Configuration
- `DRAM_TIMEOUT_EN` defined:
  - A watchdog counter, `$clog2(TIMEOUT_CYC+1)` bits wide, clears on every state entry.
  - It increments each cycle in WRITEBACK/REFILL.
  - When it reaches `TIMEOUT_CYC` without `mem_ready`:
    - the strobe drops,
    - `bus_err` pulses for 1 cycle,
    - the FSM goes to IDLE with no `fill_valid`.
  - `mem_ready` in the same cycle as expiry wins; no error is raised.
- Not defined: no counter, `bus_err` tied 0, and the block waits forever.

## Test plan
- Clean miss:
  - Stimulus: `fill_addr`=0x1000; DRAM returns 0xAAAA…A after a 4-cycle latency.
  - Required: `rden`=1 only, with `dram_addr`=0x1000; `wren` never high; `fill_valid` 1 cycle after `mem_ready` with `fill_data`=0xAAAA…A; `stall` falls in the DONE cycle.
- Dirty miss:
  - Stimulus: `wb_addr`=0x2000, `wb_data`=0x5555…5, `fill_addr`=0x3000.
  - Required: `wren` first with 0x2000 and 0x5555…5; then `rden` with 0x3000, starting the cycle after the first `mem_ready`; a single `fill_valid`.
- Input change after acceptance:
  - Stimulus: change `fill_addr` to 0xDEAD and toggle `miss_valid` during REFILL.
  - Required: `dram_addr` stays 0x1000; no second transaction starts.
- Reset mid-transaction:
  - Stimulus: pulse `rst_n` low during REFILL.
  - Required: `rden`=0 asynchronously; state=IDLE; no `fill_valid`; the next miss completes normally.
- With `DRAM_TIMEOUT_EN`, `TIMEOUT_CYC`=8:
  - Stimulus: hold `mem_ready`=0.
  - Required: `bus_err` pulses after 8 REFILL cycles; `rden` drops; `stall` drops.
  - Also: `mem_ready` on exactly cycle 8 gives `fill_valid` and no `bus_err`.
- Back-to-back misses:
  - Stimulus: `miss_valid` held high through DONE.
  - Required: the next transaction is accepted in the IDLE cycle after DONE, never in DONE.
